// File: rtl/axi_mux2_serial_pkg.sv
// Shared AXI channel structs and FSM state encodings for the 2:1 serial AXI mux.
package axi_conf;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int USER_W = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [USER_W-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic [USER_W-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way grant: round-robin with a 1-bit preference pointer, or fixed priority (port 0).
module axi_rr_arb2 #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_idx
);

    logic ptr;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        if (req == 2'b11) gnt_idx = RR_ENABLE ? ptr : 1'b0;
        else              gnt_idx = req[1] & ~req[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    ptr <= 1'b0;
        else if (RR_ENABLE && take) ptr <= ~gnt_idx;
    end

endmodule

// File: rtl/axi_mux2_serial.sv
// 2:1 AXI mux with independent write and read FSMs; one transaction per direction in flight.
module axi_mux2_serial
    import axi_conf::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  axi_conf::req_t  slv0_req_i,
    output axi_conf::resp_t slv0_resp_o,
    input  axi_conf::req_t  slv1_req_i,
    output axi_conf::resp_t slv1_resp_o,
    output axi_conf::req_t  mst_req_o,
    input  axi_conf::resp_t mst_resp_i,
    output logic            wr_owner_o,
    output logic            rd_owner_o,
    output logic            busy_o
);

    wr_state_e  wr_state;
    rd_state_e  rd_state;
    logic       wr_owner, rd_owner;
    logic       wr_gnt, rd_gnt;
    logic [1:0] aw_req, ar_req;
    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    req_t       slv_req  [2];
    resp_t      slv_resp [2];

    assign slv_req[0]  = slv0_req_i;
    assign slv_req[1]  = slv1_req_i;
    assign slv0_resp_o = slv_resp[0];
    assign slv1_resp_o = slv_resp[1];

    assign aw_req = {slv1_req_i.aw_valid, slv0_req_i.aw_valid};
    assign ar_req = {slv1_req_i.ar_valid, slv0_req_i.ar_valid};

    axi_rr_arb2 #(.RR_ENABLE(RR_ENABLE)) u_wr_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (aw_req),
        .take    ((wr_state == W_IDLE) && (|aw_req)),
        .gnt_idx (wr_gnt)
    );

    axi_rr_arb2 #(.RR_ENABLE(RR_ENABLE)) u_rd_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (ar_req),
        .take    ((rd_state == R_IDLE) && (|ar_req)),
        .gnt_idx (rd_gnt)
    );

    assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign w_hs  = mst_req_o.w_valid  & mst_resp_i.w_ready;
    assign b_hs  = mst_req_o.b_ready  & mst_resp_i.b_valid;
    assign ar_hs = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign r_hs  = mst_req_o.r_ready  & mst_resp_i.r_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state <= W_IDLE;
            wr_owner <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (|aw_req) begin
                    wr_owner <= wr_gnt;
                    wr_state <= W_ADDR;
                end
                W_ADDR:  if (aw_hs) wr_state <= W_DATA;
                W_DATA:  if (w_hs && mst_req_o.w.last) wr_state <= W_RESP;
                W_RESP:  if (b_hs) wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state <= R_IDLE;
            rd_owner <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: if (|ar_req) begin
                    rd_owner <= rd_gnt;
                    rd_state <= R_ADDR;
                end
                R_ADDR:  if (ar_hs) rd_state <= R_DATA;
                R_DATA:  if (r_hs && mst_resp_i.r.last) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Payloads always follow the owner; only valid/ready are gated by FSM state,
    // which is what lets reset drop every handshake signal asynchronously.
    always_comb begin
        mst_req_o    = '0;
        slv_resp[0]  = '0;
        slv_resp[1]  = '0;
        mst_req_o.aw = slv_req[wr_owner].aw;
        mst_req_o.w  = slv_req[wr_owner].w;
        mst_req_o.ar = slv_req[rd_owner].ar;
        for (int i = 0; i < 2; i++) begin
            slv_resp[i].b = mst_resp_i.b;
            slv_resp[i].r = mst_resp_i.r;
        end
        case (wr_state)
            W_ADDR: begin
                mst_req_o.aw_valid          = slv_req[wr_owner].aw_valid;
                slv_resp[wr_owner].aw_ready = mst_resp_i.aw_ready;
            end
            W_DATA: begin
                mst_req_o.w_valid          = slv_req[wr_owner].w_valid;
                slv_resp[wr_owner].w_ready = mst_resp_i.w_ready;
            end
            W_RESP: begin
                mst_req_o.b_ready          = slv_req[wr_owner].b_ready;
                slv_resp[wr_owner].b_valid = mst_resp_i.b_valid;
            end
            default: ;
        endcase
        case (rd_state)
            R_ADDR: begin
                mst_req_o.ar_valid          = slv_req[rd_owner].ar_valid;
                slv_resp[rd_owner].ar_ready = mst_resp_i.ar_ready;
            end
            R_DATA: begin
                mst_req_o.r_ready          = slv_req[rd_owner].r_ready;
                slv_resp[rd_owner].r_valid = mst_resp_i.r_valid;
            end
            default: ;
        endcase
    end

    assign wr_owner_o = wr_owner;
    assign rd_owner_o = rd_owner;
    assign busy_o     = (wr_state != W_IDLE) || (rd_state != R_IDLE);

endmodule

// File: tb/tb_axi_mux2_serial.sv
// Directed bench for axi_mux2_serial: per-scenario tasks with hand-computed expectations.
module tb_axi_mux2_serial;
    import axi_conf::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    req_t  slv0_req, slv1_req, mst_req;
    resp_t slv0_resp, slv1_resp, mst_resp;
    logic  wr_owner, rd_owner, busy;

    req_t  wr_in [2];
    req_t  rd_in [2];
    resp_t dn_w, dn_r;

    int n_cmp = 0;
    int n_err = 0;
    int aw_cnt = 0;
    int b1_hits = 0, r1_hits = 0;
    bit watch_b1 = 0, watch_r1 = 0;
    logic [DATA_W-1:0] w_log [$];
    logic [DATA_W-1:0] rd_log [$];
    logic [ID_W-1:0] last_bid;

    always #5 clk = ~clk;

    axi_mux2_serial #(.RR_ENABLE(1'b1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv0_req_i  (slv0_req),
        .slv0_resp_o (slv0_resp),
        .slv1_req_i  (slv1_req),
        .slv1_resp_o (slv1_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .wr_owner_o  (wr_owner),
        .rd_owner_o  (rd_owner),
        .busy_o      (busy)
    );

    // Write-side and read-side stimulus live in separate variables so concurrent drivers never share one.
    always_comb begin
        slv0_req          = wr_in[0];
        slv0_req.ar       = rd_in[0].ar;
        slv0_req.ar_valid = rd_in[0].ar_valid;
        slv0_req.r_ready  = rd_in[0].r_ready;
        slv1_req          = wr_in[1];
        slv1_req.ar       = rd_in[1].ar;
        slv1_req.ar_valid = rd_in[1].ar_valid;
        slv1_req.r_ready  = rd_in[1].r_ready;
        mst_resp          = dn_w;
        mst_resp.ar_ready = dn_r.ar_ready;
        mst_resp.r        = dn_r.r;
        mst_resp.r_valid  = dn_r.r_valid;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (mst_req.aw_valid && mst_resp.aw_ready) aw_cnt <= aw_cnt + 1;
            if (mst_req.w_valid && mst_resp.w_ready) w_log.push_back(mst_req.w.data);
        end
    end

    always @(negedge clk) begin
        if (watch_b1 && slv1_resp.b_valid) b1_hits <= b1_hits + 1;
        if (watch_r1 && slv1_resp.r_valid) r1_hits <= r1_hits + 1;
    end

    function automatic logic [DATA_W-1:0] wdat(input int p, input logic [3:0] id, input int b);
        return {8'hA0, 4'(p), id, 16'(b)};
    endfunction

    function automatic logic [DATA_W-1:0] rdat(input logic [3:0] id, input int b);
        return {8'hB0, 4'h0, id, 16'(b)};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        wr_in[0] = '0; wr_in[1] = '0; rd_in[0] = '0; rd_in[1] = '0;
        dn_w = '0; dn_r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dn_w.aw_ready = 1'b1;
        dn_w.w_ready  = 1'b1;
        dn_r.ar_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // Call just after a rising edge; returns the number of rising edges until the B handshake.
    task automatic drive_write(input int p, input logic [3:0] id, input int beats,
                               input bit early, output int cycles);
        int beat; bit done, hs_aw, hs_w, hs_b; resp_t r;
        beat = 0; done = 0; cycles = 0;
        wr_in[p].aw = '{id: id, addr: 32'h1000 + 32'(id), len: 8'(beats - 1),
                        size: 3'd2, burst: 2'b01, user: 2'(p)};
        wr_in[p].aw_valid = 1'b1;
        wr_in[p].w  = '{data: wdat(p, id, 0), strb: 4'hF, last: (beats == 1), user: 2'(p)};
        wr_in[p].w_valid = early;
        wr_in[p].b_ready = 1'b1;
        while (!done && cycles < 60) begin
            @(negedge clk);
            r = (p == 1) ? slv1_resp : slv0_resp;
            hs_aw = wr_in[p].aw_valid & r.aw_ready;
            hs_w  = wr_in[p].w_valid & r.w_ready;
            hs_b  = wr_in[p].b_ready & r.b_valid;
            if (hs_b) last_bid = r.b.id;
            @(posedge clk); cycles++; #1;
            if (hs_aw) begin
                wr_in[p].aw_valid = 1'b0;
                wr_in[p].w_valid  = 1'b1;
            end
            if (hs_w) begin
                if (wr_in[p].w.last) begin
                    wr_in[p].w_valid = 1'b0;
                    dn_w.b = '{id: id, resp: 2'b00, user: 2'b00};
                    dn_w.b_valid = 1'b1;
                end else begin
                    beat++;
                    wr_in[p].w.data = wdat(p, id, beat);
                    wr_in[p].w.last = (beat == beats - 1);
                end
            end
            if (hs_b) begin
                dn_w.b_valid = 1'b0;
                done = 1;
            end
        end
        wr_in[p] = '0;
    endtask

    task automatic drive_read(input int p, input logic [3:0] id, input int beats, output int cycles);
        int beat; bit done, hs_ar, hs_r; resp_t r;
        beat = 0; done = 0; cycles = 0;
        rd_in[p].ar = '{id: id, addr: 32'h2000 + 32'(id), len: 8'(beats - 1),
                        size: 3'd2, burst: 2'b01, user: 2'(p)};
        rd_in[p].ar_valid = 1'b1;
        rd_in[p].r_ready  = 1'b1;
        while (!done && cycles < 60) begin
            @(negedge clk);
            r = (p == 1) ? slv1_resp : slv0_resp;
            hs_ar = rd_in[p].ar_valid & r.ar_ready;
            hs_r  = rd_in[p].r_ready & r.r_valid;
            if (hs_r) rd_log.push_back(r.r.data);
            @(posedge clk); cycles++; #1;
            if (hs_ar) begin
                rd_in[p].ar_valid = 1'b0;
                dn_r.r = '{id: id, data: rdat(id, 0), resp: 2'b00, last: (beats == 1), user: 2'b00};
                dn_r.r_valid = 1'b1;
            end
            if (hs_r) begin
                if (dn_r.r.last) begin
                    dn_r.r_valid = 1'b0;
                    done = 1;
                end else begin
                    beat++;
                    dn_r.r.data = rdat(id, beat);
                    dn_r.r.last = (beat == beats - 1);
                end
            end
        end
        rd_in[p] = '0;
    endtask

    task automatic test_reset();
        logic [4:0] mv; logic [9:0] sv;
        rst = 1'b1;
        wr_in[0] = '1; wr_in[1] = '1; rd_in[0] = '1; rd_in[1] = '1;
        dn_w = '1; dn_r = '1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mv = {mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready, mst_req.ar_valid, mst_req.r_ready};
            sv = {slv0_resp.aw_ready, slv0_resp.w_ready, slv0_resp.b_valid, slv0_resp.ar_ready, slv0_resp.r_valid,
                  slv1_resp.aw_ready, slv1_resp.w_ready, slv1_resp.b_valid, slv1_resp.ar_ready, slv1_resp.r_valid};
            n_cmp++; if (mv !== 5'b0) begin n_err++; $display("FAIL reset_mst_hs: got %b want 00000", mv); end
            n_cmp++; if (sv !== 10'b0) begin n_err++; $display("FAIL reset_slv_hs: got %b want 0", sv); end
            n_cmp++; if ({busy, wr_owner, rd_owner} !== 3'b000) begin
                n_err++; $display("FAIL reset_status: got %b want 000", {busy, wr_owner, rd_owner}); end
        end
        apply_reset();
    endtask

    task automatic test_write_burst();
        int cyc, wbase, awbase;
        wbase = w_log.size(); awbase = aw_cnt; b1_hits = 0;
        wr_in[0].aw = '{id: 4'h5, addr: 32'h1005, len: 8'd3, size: 3'd2, burst: 2'b01, user: 2'd0};
        wr_in[0].aw_valid = 1'b1;
        #1;
        n_cmp++; if (mst_req.aw_valid !== 1'b0) begin n_err++; $display("FAIL wb_idle_aw: got %b want 0", mst_req.aw_valid); end
        @(posedge clk); #1;
        n_cmp++; if ({mst_req.aw_valid, mst_req.aw.id, mst_req.aw.len} !== {1'b1, 4'h5, 8'd3}) begin
            n_err++; $display("FAIL wb_aw_fwd: got %b/%h/%0d want 1/5/3", mst_req.aw_valid, mst_req.aw.id, mst_req.aw.len); end
        n_cmp++; if ({wr_owner, slv1_resp.aw_ready, busy} !== 3'b001) begin
            n_err++; $display("FAIL wb_owner: got %b want 001", {wr_owner, slv1_resp.aw_ready, busy}); end
        watch_b1 = 1;
        drive_write(0, 4'h5, 4, 1'b0, cyc);
        watch_b1 = 0;
        n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL wb_cycles: got %0d want 6", cyc); end
        n_cmp++; if (aw_cnt - awbase !== 1) begin n_err++; $display("FAIL wb_aw_count: got %0d want 1", aw_cnt - awbase); end
        n_cmp++; if (w_log.size() - wbase !== 4) begin n_err++; $display("FAIL wb_beats: got %0d want 4", w_log.size() - wbase); end
        else begin
            n_cmp++; if ({w_log[wbase], w_log[wbase+3]} !== {32'hA005_0000, 32'hA005_0003}) begin
                n_err++; $display("FAIL wb_data: got %h %h want a0050000 a0050003", w_log[wbase], w_log[wbase+3]); end
        end
        n_cmp++; if (last_bid !== 4'h5) begin n_err++; $display("FAIL wb_bid: got %h want 5", last_bid); end
        n_cmp++; if (b1_hits !== 0) begin n_err++; $display("FAIL wb_slv1_bvalid: got %0d want 0", b1_hits); end
    endtask

    task automatic test_rr_read();
        int cyc, rbase;
        apply_reset();
        rbase = rd_log.size(); r1_hits = 0;
        rd_in[0].ar = '{id: 4'h1, addr: 32'h2001, len: 8'd0, size: 3'd2, burst: 2'b01, user: 2'd0};
        rd_in[1].ar = '{id: 4'h2, addr: 32'h2002, len: 8'd0, size: 3'd2, burst: 2'b01, user: 2'd1};
        rd_in[0].ar_valid = 1'b1; rd_in[1].ar_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({rd_owner, mst_req.ar_valid, mst_req.ar.id, slv1_resp.ar_ready} !== {1'b0, 1'b1, 4'h1, 1'b0}) begin
            n_err++; $display("FAIL rr_first: got own=%b v=%b id=%h r1=%b want 0/1/1/0",
                              rd_owner, mst_req.ar_valid, mst_req.ar.id, slv1_resp.ar_ready); end
        watch_r1 = 1;
        drive_read(0, 4'h1, 1, cyc);
        watch_r1 = 0;
        n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL rr_p0_cycles: got %0d want 2", cyc); end
        n_cmp++; if ({rd_owner, mst_req.ar_valid} !== 2'b00) begin
            n_err++; $display("FAIL rr_gap: got %b want 00", {rd_owner, mst_req.ar_valid}); end
        n_cmp++; if (r1_hits !== 0) begin n_err++; $display("FAIL rr_slv1_rvalid: got %0d want 0", r1_hits); end
        @(posedge clk); #1;
        n_cmp++; if ({rd_owner, mst_req.ar_valid, mst_req.ar.id, slv1_resp.ar_ready, slv0_resp.ar_ready}
                     !== {1'b1, 1'b1, 4'h2, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL rr_second: got own=%b v=%b id=%h want 1/1/2", rd_owner, mst_req.ar_valid, mst_req.ar.id); end
        drive_read(1, 4'h2, 1, cyc);
        n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL rr_p1_cycles: got %0d want 2", cyc); end
        n_cmp++; if (rd_log.size() - rbase !== 2) begin n_err++; $display("FAIL rr_beats: got %0d want 2", rd_log.size() - rbase); end
        else begin
            n_cmp++; if ({rd_log[rbase], rd_log[rbase+1]} !== {32'hB001_0000, 32'hB002_0000}) begin
                n_err++; $display("FAIL rr_data: got %h %h want b0010000 b0020000", rd_log[rbase], rd_log[rbase+1]); end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, wbase;
        wbase = w_log.size();
        drive_write(1, 4'h3, 1, 1'b0, c1);
        drive_write(1, 4'h4, 1, 1'b0, c2);
        n_cmp++; if ({c1, c2} !== {32'd4, 32'd4}) begin n_err++; $display("FAIL b2b_cycles: got %0d %0d want 4 4", c1, c2); end
        n_cmp++; if (wr_owner !== 1'b1) begin n_err++; $display("FAIL b2b_owner: got %b want 1", wr_owner); end
        n_cmp++; if (w_log.size() - wbase !== 2) begin n_err++; $display("FAIL b2b_beats: got %0d want 2", w_log.size() - wbase); end
        else begin
            n_cmp++; if ({w_log[wbase], w_log[wbase+1]} !== {32'hA013_0000, 32'hA014_0000}) begin
                n_err++; $display("FAIL b2b_data: got %h %h want a0130000 a0140000", w_log[wbase], w_log[wbase+1]); end
        end
    endtask

    task automatic test_concurrent();
        int cw, cr, drops, rbase; logic fin;
        drops = 0; rbase = rd_log.size();
        fork
            drive_write(0, 4'h6, 4, 1'b0, cw);
            drive_read(1, 4'h7, 3, cr);
            begin
                @(negedge clk);
                for (int k = 1; k <= 6; k++) begin
                    @(negedge clk);
                    if (busy !== 1'b1) drops++;
                end
                @(negedge clk);
                fin = busy;
            end
        join
        n_cmp++; if ({cw, cr} !== {32'd7, 32'd5}) begin n_err++; $display("FAIL conc_cycles: got %0d %0d want 7 5", cw, cr); end
        n_cmp++; if (drops !== 0) begin n_err++; $display("FAIL conc_busy_hold: got %0d drops want 0", drops); end
        n_cmp++; if (fin !== 1'b0) begin n_err++; $display("FAIL conc_busy_end: got %b want 0", fin); end
        n_cmp++; if ({wr_owner, rd_owner} !== 2'b01) begin n_err++; $display("FAIL conc_owners: got %b want 01", {wr_owner, rd_owner}); end
        n_cmp++; if (rd_log.size() - rbase !== 3) begin n_err++; $display("FAIL conc_rbeats: got %0d want 3", rd_log.size() - rbase); end
        else begin
            n_cmp++; if (rd_log[rbase+2] !== 32'hB007_0002) begin
                n_err++; $display("FAIL conc_rdata: got %h want b0070002", rd_log[rbase+2]); end
        end
    endtask

    task automatic test_early_w();
        int c, stalls, wbase;
        stalls = 0; wbase = w_log.size();
        wr_in[0].w = '{data: 32'hA008_0000, strb: 4'hF, last: 1'b0, user: 2'd0};
        wr_in[0].w_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (slv0_resp.w_ready || mst_req.w_valid) stalls++;
        end
        @(posedge clk); #1;
        drive_write(0, 4'h8, 2, 1'b1, c);
        n_cmp++; if (stalls !== 0) begin n_err++; $display("FAIL early_w_stall: got %0d leaks want 0", stalls); end
        n_cmp++; if (c !== 5) begin n_err++; $display("FAIL early_w_cycles: got %0d want 5", c); end
        n_cmp++; if (w_log.size() - wbase !== 2) begin n_err++; $display("FAIL early_w_beats: got %0d want 2", w_log.size() - wbase); end
        else begin
            n_cmp++; if ({w_log[wbase], w_log[wbase+1]} !== {32'hA008_0000, 32'hA008_0001}) begin
                n_err++; $display("FAIL early_w_order: got %h %h want a0080000 a0080001", w_log[wbase], w_log[wbase+1]); end
        end
    endtask

    task automatic test_reset_mid();
        int c, wbase;
        wr_in[1].aw = '{id: 4'h9, addr: 32'h1009, len: 8'd3, size: 3'd2, burst: 2'b01, user: 2'd1};
        wr_in[1].aw_valid = 1'b1;
        wr_in[1].b_ready  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_in[1].aw_valid = 1'b0;
        wr_in[1].w = '{data: 32'hA019_0000, strb: 4'hF, last: 1'b0, user: 2'd1};
        wr_in[1].w_valid = 1'b1;
        @(posedge clk); #1;
        wr_in[1].w.data = 32'hA019_0001;
        #1;
        n_cmp++; if ({mst_req.w_valid, mst_req.w.data, wr_owner} !== {1'b1, 32'hA019_0001, 1'b1}) begin
            n_err++; $display("FAIL rmid_pre: got v=%b d=%h own=%b want 1/a0190001/1", mst_req.w_valid, mst_req.w.data, wr_owner); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if ({mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready, slv1_resp.w_ready} !== 4'b0000) begin
            n_err++; $display("FAIL rmid_drop: got %b want 0000",
                              {mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready, slv1_resp.w_ready}); end
        n_cmp++; if ({busy, wr_owner} !== 2'b00) begin n_err++; $display("FAIL rmid_state: got %b want 00", {busy, wr_owner}); end
        apply_reset();
        wbase = w_log.size();
        drive_write(0, 4'hA, 1, 1'b0, c);
        n_cmp++; if (c !== 4) begin n_err++; $display("FAIL rmid_recover: got %0d want 4", c); end
        n_cmp++; if (w_log.size() - wbase !== 1) begin n_err++; $display("FAIL rmid_beats: got %0d want 1", w_log.size() - wbase); end
        else begin
            n_cmp++; if (w_log[wbase] !== 32'hA00A_0000) begin
                n_err++; $display("FAIL rmid_data: got %h want a00a0000", w_log[wbase]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_rr_read();
        test_back_to_back();
        test_concurrent();
        test_early_w();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_mux2_serial.md
AXI_MUX2_SERIAL -- requirements
Module: axi_mux2_serial

Interface
REQ-001 SHALL have parameter RR_ENABLE, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with port 0 winning.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port slv0_req_i, input, axi_conf::req_t: requester 0 request.
REQ-005 SHALL have port slv0_resp_o, output, axi_conf::resp_t: requester 0 response.
REQ-006 SHALL have ports slv1_req_i and slv1_resp_o, matching REQ-004 and REQ-005, for requester 1.
REQ-007 SHALL have port mst_req_o, output, axi_conf::req_t: request to the shared downstream port.
REQ-008 SHALL have port mst_resp_i, input, axi_conf::resp_t: response from the shared downstream port.
REQ-009 SHALL have ports wr_owner_o and rd_owner_o, outputs, 1 bit each: the current write and read grant index.
REQ-010 SHALL have port busy_o, output, 1 bit: high when either FSM is outside IDLE.

Function
REQ-011 SHALL run independent write and read FSMs; one write and one read may be in flight concurrently.
REQ-012 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA and W_RESP.
REQ-013 In W_IDLE, if any aw_valid is set, the FSM SHALL register the winner into wr_owner and go to W_ADDR on the next edge; no AW is forwarded in W_IDLE.
REQ-014 In W_ADDR, mst aw and aw_valid SHALL come from the owner, and the owner aw_ready SHALL be mst aw_ready; on the AW handshake the FSM SHALL go to W_DATA.
REQ-015 In W_DATA, W and w_valid SHALL be forwarded from the owner, and w_ready returned to it; on a handshake with w.last=1 the FSM SHALL go to W_RESP.
REQ-016 In W_RESP, B SHALL be forwarded to the owner with b_ready from the owner; on the B handshake the FSM SHALL go to W_IDLE.
REQ-017 Read FSM SHALL have states R_IDLE, R_ADDR and R_DATA, using the same grant rules on ar_valid.
REQ-018 Read FSM SHALL forward AR in R_ADDR and R beats in R_DATA, and SHALL return to R_IDLE on an R handshake with r.last=1.
REQ-019 The non-owner SHALL see aw_ready, w_ready, ar_ready, b_valid and r_valid at 0 at all times.
REQ-020 Outside the owning states, mst valid and ready signals for that channel SHALL be 0.
REQ-021 W beats presented before the AW handshake SHALL be stalled (w_ready=0), never buffered.
REQ-022 Payload fields, including id and user, SHALL pass through unmodified and combinationally; the only added latency is 1 cycle from valid to a forwarded AW or AR.
REQ-023 With RR_ENABLE=1, a separate 1-bit pointer per direction SHALL name the preferred port; on each grant the pointer SHALL move to the non-granted port.
REQ-024 If only one port is valid, that port SHALL win regardless of the pointer.
REQ-025 With RR_ENABLE=0, port 0 SHALL always win a tie and the pointers SHALL be unused.
REQ-026 A requester dropping aw_valid or ar_valid before its handshake is an AXI protocol violation; the grant SHALL hold until the handshake.
REQ-027 A burst of len=0 SHALL be handled identically, as a single beat with last=1.
REQ-028 Both write and read grants going to the same port SHALL be legal.

Reset
REQ-029 While rst_i=1, both FSMs SHALL be IDLE, both pointers 0, wr_owner_o and rd_owner_o 0, and busy_o 0.
REQ-030 While rst_i=1, every mst valid and ready, and every slave ready and valid, SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately; recovery of the downstream port is the system's responsibility.

Structure
REQ-032 axi_conf SHALL hold req_t, resp_t and the FSM state enums (wr_state_e, rd_state_e).
REQ-033 One sub-module SHALL be natural: axi_rr_arb2, a 2-way round-robin or fixed-priority grant with pointer, instantiated once per direction.

Verification
REQ-034 Port 0 writes a 4-beat burst (awlen=3, id=0x5) -> one AW downstream 1 cycle after awvalid, 4 W beats, B id=0x5 to port 0 only, and slv1 b_valid stays 0.
REQ-035 Both ports assert arvalid in the same cycle after reset, RR_ENABLE=1 -> port 0 is served first, port 1 is granted on the cycle after port 0's rlast handshake, and rd_owner_o reads 0 then 1.
REQ-036 Port 1 repeatedly requests writes with port 0 idle -> port 1 gets back-to-back grants and never stalls on the pointer.
REQ-037 Port 0 writes while port 1 reads concurrently -> both complete, and busy_o stays 1 until the later completion.
REQ-038 Port 0 presents wvalid 3 cycles before awvalid -> w_ready stays 0 until the AW handshake, and data arrives in order.
REQ-039 rst_i pulsed during W_DATA beat 2 of 4 -> all valids drop asynchronously, FSMs return to IDLE, and the next request is granted normally after release.
